alien_shot_scheduler: RTL and testbench

//  Downstream of the alien formation: consumes its per-alien armed matrix and decides which alien fires next.

---
 rtl/game_pkg.sv | 25 ++
 rtl/column_armed_select.sv | 35 +++
 rtl/alien_shot_scheduler.sv | 150 +++++++++++++++
 tb/tb_alien_shot_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the alien shot scheduler slice.
//   shot_state_e : scheduler FSM states
//   LFSR_TAPS    : feedback mask of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   idx_w()      : index width helper, never narrower than one bit
//   lfsr_next()  : one right-shift step of the LFSR
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        REQUEST = 2'd2
    } shot_state_e;

    // Taps 16,14,13,11 map to bits 0,2,3,5 of a right-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/column_armed_select.sv
// Combinational column probe for the alien formation.
//   armed_matrix : [row][col] packed armed bits (bit = row*NUM_COLUMNS + col)
//   col          : column under examination
//   hit_c        : any alien armed in that column
//   row_c        : highest-index (bottom-most) armed row, 0 when no hit
module column_armed_select
    import game_pkg::*;
#(
    parameter int unsigned NUM_ROWS    = 2,
    parameter int unsigned NUM_COLUMNS = 4
) (
    input  logic [NUM_ROWS*NUM_COLUMNS-1:0] armed_matrix,
    input  logic [idx_w(NUM_COLUMNS)-1:0]   col,
    output logic                            hit_c,
    output logic [idx_w(NUM_ROWS)-1:0]      row_c
);

    localparam int unsigned ROW_W = idx_w(NUM_ROWS);
    localparam int unsigned COL_W = idx_w(NUM_COLUMNS);

    // Ascending row scan so the last match (bottom-most row) wins.
    always_comb begin
        hit_c = 1'b0;
        row_c = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                if ((COL_W'(c) == col) && armed_matrix[r*NUM_COLUMNS + c]) begin
                    hit_c = 1'b1;
                    row_c = ROW_W'(r);
                end
            end
        end
    end

endmodule

// File: rtl/alien_shot_scheduler.sv
// Decides which alien fires next and issues one (row, col) request per shot.
// Cooldown paced by frame_tick, column scan from a start column, valid/ready
// handoff to the bullet engine.
// Build option: ALIEN_SHOT_LFSR_EN selects an LFSR-derived start column;
// otherwise a round-robin pointer that follows the last accepted column.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   enable         : 0 holds the scheduler idle with the cooldown frozen
//   frame_tick     : one-cycle pulse per video frame
//   armed_matrix   : [row][col] packed, 1 = alien may fire
//   fire_valid/ready, fire_row, fire_col : fire request handshake
//   no_shooter     : one-cycle pulse when a full scan finds nobody armed
module alien_shot_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_ROWS        = 2,
    parameter int unsigned NUM_COLUMNS     = 4,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            frame_tick,
    input  logic [NUM_ROWS*NUM_COLUMNS-1:0] armed_matrix,
    output logic                            fire_valid,
    input  logic                            fire_ready,
    output logic [idx_w(NUM_ROWS)-1:0]      fire_row,
    output logic [idx_w(NUM_COLUMNS)-1:0]   fire_col,
    output logic                            no_shooter
);

    localparam int unsigned ROW_W = idx_w(NUM_ROWS);
    localparam int unsigned COL_W = idx_w(NUM_COLUMNS);
    localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLUMNS - 1);

    // Elaboration-time parameter sanity.
    if (COOLDOWN_FRAMES < 1) begin : g_bad_cooldown
        $error("alien_shot_scheduler: COOLDOWN_FRAMES must be >= 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("alien_shot_scheduler: LFSR_SEED must be nonzero");
    end

    shot_state_e      state;
    logic [CNT_W-1:0] cooldown;
    logic [COL_W-1:0] scan_col;
    logic [COL_W-1:0] scan_cnt;
    logic             hit_c;
    logic [ROW_W-1:0] sel_row_c;
    logic [COL_W-1:0] start_col_c;

    // Modulo-NUM_COLUMNS increment, valid for non-power-of-two widths.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
        return (c == LAST_COL) ? '0 : c + COL_W'(1);
    endfunction

    column_armed_select #(
        .NUM_ROWS    (NUM_ROWS),
        .NUM_COLUMNS (NUM_COLUMNS)
    ) u_sel (
        .armed_matrix (armed_matrix),
        .col          (scan_col),
        .hit_c        (hit_c),
        .row_c        (sel_row_c)
    );

`ifdef ALIEN_SHOT_LFSR_EN
    logic [15:0] lfsr;

    // Free-running LFSR; start column is its current value mod NUM_COLUMNS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next(lfsr);
    end

    assign start_col_c = COL_W'(lfsr % 16'(NUM_COLUMNS));
`else
    logic [COL_W-1:0] ptr;

    assign start_col_c = ptr;
`endif

    // Scheduler FSM with registered request/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cooldown   <= COOL_INIT;
            scan_col   <= '0;
            scan_cnt   <= '0;
            fire_valid <= 1'b0;
            fire_row   <= '0;
            fire_col   <= '0;
            no_shooter <= 1'b0;
`ifndef ALIEN_SHOT_LFSR_EN
            ptr        <= '0;
`endif
        end else begin
            no_shooter <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && frame_tick) begin
                        // Saturate at zero; the 1->0 step launches the scan.
                        if (cooldown <= CNT_W'(1)) begin
                            cooldown <= '0;
                            scan_col <= start_col_c;
                            scan_cnt <= '0;
                            state    <= SCAN;
                        end else begin
                            cooldown <= cooldown - CNT_W'(1);
                        end
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        cooldown <= COOL_INIT;
                        state    <= IDLE;
                    end else if (hit_c) begin
                        fire_valid <= 1'b1;
                        fire_row   <= sel_row_c;
                        fire_col   <= scan_col;
                        state      <= REQUEST;
                    end else if (scan_cnt == LAST_COL) begin
                        no_shooter <= 1'b1;
                        cooldown   <= COOL_INIT;
                        state      <= IDLE;
                    end else begin
                        scan_col <= next_col(scan_col);
                        scan_cnt <= scan_cnt + COL_W'(1);
                    end
                end
                REQUEST: begin
                    // Request is never retracted; only acceptance ends it.
                    if (fire_ready) begin
                        fire_valid <= 1'b0;
                        cooldown   <= COOL_INIT;
                        state      <= IDLE;
`ifndef ALIEN_SHOT_LFSR_EN
                        ptr        <= next_col(fire_col);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Self-checking bench for alien_shot_scheduler (2 rows, 4 columns, cooldown 2).
// Stimulus pushes the expected (row, col) of each shot into a queue; a monitor
// on the falling edge compares every presented request against the queue head
// and pops on handshake. With ALIEN_SHOT_LFSR_EN the monitor instead checks
// each shot's start column against a bench LFSR model.
module tb_alien_shot_scheduler;

    localparam int unsigned NR = 2;
    localparam int unsigned NC = 4;
    localparam int unsigned CD = 2;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          enable       = 1'b0;
    logic          frame_tick   = 1'b0;
    logic          fire_ready   = 1'b0;
    logic [NR*NC-1:0] armed_matrix = '0;
    logic          fire_valid;
    logic          no_shooter;
    logic [0:0]    fire_row;
    logic [1:0]    fire_col;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [0:0] row;
        logic [1:0] col;
    } shot_t;

    shot_t exp_q[$];

    always #5 clk = ~clk;

    alien_shot_scheduler #(
        .NUM_ROWS        (NR),
        .NUM_COLUMNS     (NC),
        .COOLDOWN_FRAMES (CD),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .armed_matrix (armed_matrix),
        .fire_valid   (fire_valid),
        .fire_ready   (fire_ready),
        .fire_row     (fire_row),
        .fire_col     (fire_col),
        .no_shooter   (no_shooter)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Cycles until fire_valid shows, bounded at 20.
    task automatic wait_valid(input string name, input int exp_cycles);
        int n = 0;
        while (!fire_valid && n < 20) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic accept();
        fire_ready = 1'b1;
        step();
        fire_ready = 1'b0;
        check("valid_drop_after_accept", 32'(fire_valid), 32'd0);
    endtask

    task automatic expect_shot(input logic [0:0] r, input logic [1:0] c);
        shot_t s;
        s.row = r;
        s.col = c;
        exp_q.push_back(s);
    endtask

`ifdef ALIEN_SHOT_LFSR_EN
    function automatic logic [15:0] model_step(input logic [15:0] m);
        return {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    endfunction

    logic [15:0] m_lfsr, m_d1, m_d2;
    logic        prev_v = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_d1   <= 16'hACE1;
            m_d2   <= 16'hACE1;
        end else begin
            m_lfsr <= model_step(m_lfsr);
            m_d1   <= m_lfsr;
            m_d2   <= m_d1;
        end
    end

    // Start column was sampled two edges before fire_valid rises.
    always @(negedge clk) begin
        if (rst_n && fire_valid && !prev_v) begin
            check("lfsr_start_col", 32'(fire_col), 32'(m_d2 % 16'd4));
            check("lfsr_row", 32'(fire_row), 32'd1);
        end
        prev_v = fire_valid;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        enable       = 1'b1;
        armed_matrix = '1;
        fire_ready   = 1'b1;
        step();
        for (int s = 0; s < 20; s++) begin
            tick();
            tick();
            wait_valid("lfsr_latency", 1);
            step();
            check("lfsr_valid_drop", 32'(fire_valid), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
`else
    // Scoreboard monitor: every presented request must match the queue head.
    always @(negedge clk) begin
        if (rst_n && fire_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fire: row %0d col %0d, expected no request", fire_row, fire_col);
            end else begin
                check("fire_row", 32'(fire_row), 32'(exp_q[0].row));
                check("fire_col", 32'(fire_col), 32'(exp_q[0].col));
                if (fire_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int ns;
        int at;
        repeat (2) @(posedge clk);
        #1;
        check("reset_fire_valid", 32'(fire_valid), 32'd0);
        check("reset_fire_row",   32'(fire_row),   32'd0);
        check("reset_fire_col",   32'(fire_col),   32'd0);
        check("reset_no_shooter", 32'(no_shooter), 32'd0);
        rst_n        = 1'b1;
        enable       = 1'b1;
        armed_matrix = '1;
        step();

        // 1: all armed, two ticks -> bottom row, column 0
        expect_shot(1'b1, 2'd0);
        tick();
        step();
        step();
        check("t1_one_tick_no_fire", 32'(fire_valid), 32'd0);
        tick();
        check("t1_not_yet", 32'(fire_valid), 32'd0);
        wait_valid("t1_latency", 1);

        // 2: held request under backpressure, then next shot at column 1
        repeat (10) step();
        check("t2_still_valid", 32'(fire_valid), 32'd1);
        accept();
        expect_shot(1'b1, 2'd1);
        tick();
        tick();
        wait_valid("t2_next_latency", 1);
        accept();

        // 3: only [0][3] armed from pointer 0 -> four scan cycles, then wrap
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n        = 1'b1;
        armed_matrix = 8'h08;
        expect_shot(1'b0, 2'd3);
        tick();
        tick();
        wait_valid("t3_scan_latency", 4);
        accept();
        armed_matrix = '1;
        expect_shot(1'b1, 2'd0);
        tick();
        tick();
        wait_valid("t3_wrap_latency", 1);
        accept();

        // 4: nothing armed -> single no_shooter pulse after four scan cycles
        armed_matrix = '0;
        tick();
        tick();
        ns = 0;
        at = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (no_shooter) begin
                ns++;
                at = i;
            end
        end
        check("t4_pulse_count", 32'(ns), 32'd1);
        check("t4_pulse_cycle", 32'(at), 32'd4);
        armed_matrix = '1;
        expect_shot(1'b1, 2'd1);
        tick();
        repeat (3) step();
        check("t4_cooldown_reloaded", 32'(fire_valid), 32'd0);
        tick();
        wait_valid("t4_after_reload", 1);

        // 5: async reset while a request is pending
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5_async_drop", 32'(fire_valid), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        expect_shot(1'b1, 2'd0);
        tick();
        repeat (5) step();
        check("t5_full_cooldown", 32'(fire_valid), 32'd0);
        tick();
        wait_valid("t5_latency", 1);
        accept();

        // frame_tick ignored while disabled
        enable = 1'b0;
        tick();
        tick();
        repeat (3) step();
        check("disabled_no_fire", 32'(fire_valid), 32'd0);
        enable = 1'b1;
        expect_shot(1'b1, 2'd1);
        tick();
        tick();
        wait_valid("enabled_fire", 1);
        accept();

        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
`endif

endmodule
